// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Shared state encoding and default width for the serial adder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
// Module : full_adder (built from two half_adder instances)
// Brief  : One-bit adder cell shared by every bit position of the serial adder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic w_s0;
  logic w_c0;
  logic w_c1;

  half_adder u_ha0 (.a(a),    .b(b),   .s(w_s0), .c(w_c0));
  half_adder u_ha1 (.a(w_s0), .b(cin), .s(sum),  .c(w_c1));

  assign cout = w_c0 | w_c1;
endmodule

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// ============================================================================
// Module : serial_add_ctrl
// Brief  : Bit-serial add/subtract, LSB first, one bit per clock through a
//          single full-adder cell; results registered on completion.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_add_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);

  localparam int             CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   work;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic               fa_sum;
  logic               fa_cout;

  full_adder u_fa (
    .a    (a_reg[0]),
    .b    (b_reg[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      S     <= '0;
      Cout  <= 1'b0;
      Ovf   <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      work  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          a_reg <= a_reg >> 1;
          b_reg <= b_reg >> 1;
          work  <= {fa_sum, work[WIDTH-1:1]};
          carry <= fa_cout;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            // carry still holds the carry into the MSB on this last bit
            S     <= {fa_sum, work[WIDTH-1:1]};
            Cout  <= fa_cout;
            Ovf   <= carry ^ fa_cout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= A;
            b_reg <= B ^ {WIDTH{op_sub}};
            carry <= op_sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// ============================================================================
// Module : tb_serial_add_ctrl
// Brief  : Self-checking bench for serial_add_ctrl against an arithmetic model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_add_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         op_sub = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] S;
  logic         Cout;
  logic         Ovf;

  int tests = 0;
  int fails = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op_sub (op_sub),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .S      (S),
    .Cout   (Cout),
    .Ovf    (Ovf)
  );

  always #5 clk = ~clk;

  // Returns {ovf, cout, sum} from plain wide arithmetic and sign rules.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub);
    logic [W:0]   full;
    logic [W-1:0] s;
    logic         ovf;
    if (sub) begin
      full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      s    = full[W-1:0];
      ovf  = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
    end else begin
      full = {1'b0, a} + {1'b0, b};
      s    = full[W-1:0];
      ovf  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    end
    return {ovf, full[W], s};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation from IDLE; inputs are scrambled every RUN cycle and an
  // extra start pulse is injected at RUN cycle inject_at (negative = none).
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input int inject_at);
    logic [W+1:0] exp;
    logic [W-1:0] s_before;
    int           cycles;
    int           busy_cnt;
    bit           held;
    exp      = model(a, b, sub);
    s_before = S;
    A = a; B = b; op_sub = sub; start = 1'b1;
    tick();
    start    = 1'b0;
    cycles   = 0;
    busy_cnt = 0;
    held     = 1'b1;
    while (done !== 1'b1 && cycles < 100) begin
      if (busy === 1'b1) busy_cnt++;
      if (S !== s_before) held = 1'b0;
      A      = $urandom;
      B      = $urandom;
      op_sub = 1'($urandom_range(0, 1));
      start  = (cycles == inject_at);
      tick();
      cycles++;
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(cycles), 64'(W));
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(W));
    check({tag, " S_held"}, 64'(held), 64'd1);
    check({tag, " S"}, 64'(S), 64'(exp[W-1:0]));
    check({tag, " Cout"}, 64'(Cout), 64'(exp[W]));
    check({tag, " Ovf"}, 64'(Ovf), 64'(exp[W+1]));
    check({tag, " busy_in_done"}, 64'(busy), 64'd0);
    tick();
    check({tag, " done_pulse"}, 64'(done), 64'd0);
    check({tag, " idle_busy"}, 64'(busy), 64'd0);
    check({tag, " S_after"}, 64'(S), 64'(exp[W-1:0]));
  endtask

  initial begin
    logic [W+1:0] exp;
    int           done_at[$];
    int           bad;
    bit           spurious;

    // Asynchronous reset, checked before any clock edge
    #2 rst = 1'b1;
    #1;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst S", 64'(S), 64'd0);
    check("rst Cout", 64'(Cout), 64'd0);
    check("rst Ovf", 64'(Ovf), 64'd0);
    tick(); tick();
    #2 rst = 1'b0;
    tick();
    check("idle busy", 64'(busy), 64'd0);

    run_op("add5+3", 32'd5, 32'd3, 1'b0, -1);
    run_op("addFF+1", 32'hFFFF_FFFF, 32'd1, 1'b0, -1);
    run_op("add7F+1", 32'h7FFF_FFFF, 32'd1, 1'b0, -1);
    run_op("sub5-7", 32'd5, 32'd7, 1'b1, -1);
    run_op("sub80-1", 32'h8000_0000, 32'd1, 1'b1, -1);
    run_op("sub0-0", 32'd0, 32'd0, 1'b1, -1);

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("rand%0d", i), $urandom, $urandom, 1'($urandom_range(0, 1)), -1);
    end

    // Extra start mid-run is ignored: one done only, first operands' result
    run_op("ignore_start", 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 10);
    spurious = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
      tick();
    end
    check("ignore_start no_second_op", 64'(spurious), 64'd0);

    // Reset between edges mid-run aborts with no done
    A = 32'hDEAD_BEEF; B = 32'h1111_1111; op_sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    #2 rst = 1'b1;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort S", 64'(S), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort Cout", 64'(Cout), 64'd0);
    check("abort Ovf", 64'(Ovf), 64'd0);
    #1 rst = 1'b0;
    spurious = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
    end
    check("abort no_done", 64'(spurious), 64'd0);
    run_op("post_rst 2+2", 32'd2, 32'd2, 1'b0, -1);

    // Start held high: back-to-back operations every W+1 cycles
    exp = model(32'hCAFE_0001, 32'h0000_FFFF, 1'b1);
    A = 32'hCAFE_0001; B = 32'h0000_FFFF; op_sub = 1'b1; start = 1'b1;
    bad = 0;
    for (int n = 0; n < 3 * (W + 1) + 2; n++) begin
      tick();
      if (busy === done) bad++;
      if (done === 1'b1) done_at.push_back(n);
    end
    start = 1'b0;
    check("b2b done_count", 64'(done_at.size()), 64'd3);
    check("b2b busy_vs_done", 64'(bad), 64'd0);
    if (done_at.size() == 3) begin
      check("b2b first_done", 64'(done_at[0]), 64'(W));
      check("b2b period1", 64'(done_at[1] - done_at[0]), 64'(W + 1));
      check("b2b period2", 64'(done_at[2] - done_at[1]), 64'(W + 1));
    end
    check("b2b S", 64'(S), 64'(exp[W-1:0]));
    check("b2b Cout", 64'(Cout), 64'(exp[W]));
    check("b2b Ovf", 64'(Ovf), 64'(exp[W+1]));
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal range 2..64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request a new operation; sampled on clk rising edge.
REQ-005 SHALL have port op_sub  input  1  0 = A+B, 1 = A-B; sampled with start.
REQ-006 SHALL have port A  input  WIDTH  first operand; sampled with start.
REQ-007 SHALL have port B  input  WIDTH  second operand; sampled with start.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse: result outputs just updated.
REQ-010 SHALL have port S  output  WIDTH  registered result.
REQ-011 SHALL have port Cout  output  1  registered carry out of MSB (for subtract: 1 = no borrow).
REQ-012 SHALL have port Ovf  output  1  registered two's-complement overflow.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE; busy=1 only in RUN, done=1 only in DONE.
REQ-014 In IDLE or DONE with start=1 at an edge, SHALL latch A, B^{WIDTH{op_sub}}, carry=op_sub, bit counter=0, and enter RUN.
REQ-015 In IDLE with start=0 SHALL remain IDLE; in DONE with start=0 SHALL return to IDLE after exactly one cycle.
REQ-016 In RUN SHALL process exactly one bit per cycle, LSB first, through one shared full-adder cell; sum bit shifted into a working register, carry fed back via a 1-bit register.
REQ-017 SHALL leave RUN for DONE after exactly WIDTH RUN cycles (counter reaches WIDTH-1); busy high for exactly WIDTH cycles.
REQ-018 Latency: start sampled at edge E0 -> done high in the cycle after edge E(WIDTH), S/Cout/Ovf updated at that same edge.
REQ-019 S, Cout, Ovf SHALL change only on the RUN->DONE edge and hold otherwise, including throughout a following operation.
REQ-020 Ovf SHALL equal (carry into MSB) XOR (carry out of MSB); Cout SHALL equal carry out of MSB; result modulo 2^WIDTH.
REQ-021 start while in RUN SHALL be ignored (no latch, no restart, no queueing); A/B/op_sub changes during RUN SHALL not affect the result.
REQ-022 start in DONE SHALL be accepted (back-to-back): done=1 that cycle, RUN next cycle.

Reset
REQ-023 rst=1 SHALL immediately force IDLE, busy=0, done=0, S=0, Cout=0, Ovf=0, counter=0, carry=0, independent of clk.
REQ-024 rst asserted mid-RUN SHALL abort the operation with no done pulse; first start after rst deasserts behaves as from power-up.

Structure
REQ-025 State encoding (IDLE/RUN/DONE) and the default WIDTH constant SHALL live in shared package alu_pkg.
REQ-026 The bit cell SHALL be one sub-module, full_adder (two half_adder instances plus OR for carry); no other sub-modules.
REQ-027 Counter width SHALL be $clog2(WIDTH); no combinational path from inputs to outputs.

Verification
REQ-028 A=5, B=3, op_sub=0, start one cycle -> busy 32 cycles, done at cycle 33, S=0x00000008, Cout=0, Ovf=0.
REQ-029 A=0xFFFFFFFF, B=1, add -> S=0x00000000, Cout=1, Ovf=0; A=0x7FFFFFFF, B=1, add -> S=0x80000000, Cout=0, Ovf=1.
REQ-030 A=5, B=7, op_sub=1 -> S=0xFFFFFFFE, Cout=0, Ovf=0; A=0x80000000, B=1, sub -> S=0x7FFFFFFF, Cout=1, Ovf=1.
REQ-031 start pulsed again at RUN cycle 10 with different A/B -> ignored; single done, result of first operands; S unchanged until that done.
REQ-032 rst asserted at RUN cycle 16 between clock edges -> busy=0, S=0 immediately; no done; next start 2+2 -> S=4 after 32 cycles.
REQ-033 start held high continuously with fixed operands -> done every 33 cycles, busy low only during DONE cycles.
